// File: rtl/johnson_seq_gen.sv
// Multi-mode pattern generator: Johnson, one-hot ring, binary and Gray counter
// with a programmable prescaler, up/down direction and illegal-state recovery.
module johnson_seq_gen #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               dir,
  input  logic [1:0]         mode,
  input  logic [PRESC_W-1:0] presc,
  output logic [WIDTH-1:0]   out,
  output logic               wrap,
  output logic               err
);

  localparam logic [1:0] M_JOHNSON = 2'b00;
  localparam logic [1:0] M_RING    = 2'b01;
  localparam logic [1:0] M_BINARY  = 2'b10;
  localparam logic [1:0] M_GRAY    = 2'b11;

  logic [WIDTH-1:0]   state;
  logic [1:0]         mode_q;
  logic [PRESC_W-1:0] pcnt;

  logic               tick;
  logic               illegal;
  logic [WIDTH-1:0]   nxt;
  logic [WIDTH-1:0]   trans;
  logic [WIDTH-2:0]   edges;

  function automatic logic [WIDTH-1:0] seed_of(input logic [1:0] m);
    return (m == M_RING) ? WIDTH'(1) : '0;
  endfunction

  assign tick = en && (pcnt == presc);

  // Johnson words have at most one adjacent-bit transition; ring words are one-hot.
  assign edges = state[WIDTH-2:0] ^ state[WIDTH-1:1];
  assign trans = WIDTH'(edges);

  always_comb begin
    illegal = 1'b0;
    case (mode_q)
      M_JOHNSON: illegal = (trans & (trans - WIDTH'(1))) != '0;
      M_RING:    illegal = (state == '0) || ((state & (state - WIDTH'(1))) != '0);
      default:   illegal = 1'b0;
    endcase
  end

  always_comb begin
    nxt = state;
    case (mode_q)
      M_JOHNSON: nxt = dir ? {~state[0], state[WIDTH-1:1]}
                           : {state[WIDTH-2:0], ~state[WIDTH-1]};
      M_RING:    nxt = dir ? {state[0], state[WIDTH-1:1]}
                           : {state[WIDTH-2:0], state[WIDTH-1]};
      default:   nxt = dir ? state - WIDTH'(1) : state + WIDTH'(1);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= '0;
      mode_q <= M_JOHNSON;
      pcnt   <= '0;
      wrap   <= 1'b0;
      err    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      err  <= 1'b0;
      if (mode != mode_q) begin
        mode_q <= mode;
        state  <= seed_of(mode);
        pcnt   <= '0;
      end else if (illegal) begin
        state <= seed_of(mode_q);
        err   <= 1'b1;
        pcnt  <= '0;
      end else begin
        if (tick) begin
          state <= nxt;
          wrap  <= (nxt == seed_of(mode_q));
          pcnt  <= '0;
        end else if (en) begin
          pcnt  <= pcnt + PRESC_W'(1);
        end
      end
    end
  end

  // Gray view is decoded from the binary count so it follows state with no extra stage.
  assign out = (mode_q == M_GRAY) ? (state ^ (state >> 1)) : state;

endmodule

// File: tb/tb_johnson_seq_gen.sv
// Directed bench for johnson_seq_gen: mode sequences, prescaler, recovery, async reset.
module tb_johnson_seq_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       dir = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] presc = 8'd0;
  logic [7:0] out;
  logic       wrap;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  johnson_seq_gen #(.WIDTH(8), .PRESC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .mode(mode),
    .presc(presc), .out(out), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({out, wrap, err} !== 10'h000) begin
      n_bad++;
      $display("FAIL reset: out=%h wrap=%b err=%b required out=00 wrap=0 err=0", out, wrap, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_johnson();
    logic [7:0] exp_seq [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      n_cmp++;
      if (out !== exp_seq[i] || wrap !== (i == 15)) begin
        n_bad++;
        $display("FAIL johnson[%0d]: out=%h wrap=%b required out=%h wrap=%b",
                 i, out, wrap, exp_seq[i], (i == 15));
      end
    end
  endtask

  task automatic test_ring();
    logic [7:0] e;
    mode = 2'b01;
    step();
    n_cmp++;
    if (out !== 8'h01 || wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL ring_seed: out=%h wrap=%b required out=01 wrap=0", out, wrap);
    end
    e = 8'h01;
    for (int i = 0; i < 8; i++) begin
      step();
      e = {e[6:0], e[7]};
      n_cmp++;
      if (out !== e || wrap !== (i == 7)) begin
        n_bad++;
        $display("FAIL ring_up[%0d]: out=%h wrap=%b required out=%h wrap=%b", i, out, wrap, e, (i == 7));
      end
    end
    dir = 1'b1;
    step();
    n_cmp++;
    if (out !== 8'h80) begin
      n_bad++;
      $display("FAIL ring_dn0: out=%h required 80", out);
    end
    step();
    n_cmp++;
    if (out !== 8'h40) begin
      n_bad++;
      $display("FAIL ring_dn1: out=%h required 40", out);
    end
  endtask

  task automatic test_prescaler();
    presc = 8'd3;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (out !== ((i == 3) ? 8'h20 : 8'h40)) begin
        n_bad++;
        $display("FAIL presc_a[%0d]: out=%h required %h", i, out, (i == 3) ? 8'h20 : 8'h40);
      end
    end
    step();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (out !== 8'h20 || dut.pcnt !== 8'd1) begin
        n_bad++;
        $display("FAIL presc_hold[%0d]: out=%h pcnt=%0d required out=20 pcnt=1", i, out, dut.pcnt);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (out !== ((i == 2) ? 8'h10 : 8'h20)) begin
        n_bad++;
        $display("FAIL presc_b[%0d]: out=%h required %h", i, out, (i == 2) ? 8'h10 : 8'h20);
      end
    end
    presc = 8'd0;
  endtask

  task automatic test_binary_gray();
    logic [7:0] e;
    logic [7:0] g [8] = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04};
    mode = 2'b10;
    dir  = 1'b1;
    // a tick may be pending from the prescaler; the mode change takes priority
    step();
    n_cmp++;
    if (out !== 8'h00) begin
      n_bad++;
      $display("FAIL bin_seed: out=%h required 00", out);
    end
    e = 8'h00;
    for (int k = 1; k <= 256; k++) begin
      step();
      e = e - 8'h01;
      if (k <= 3 || k == 256) begin
        n_cmp++;
        if (out !== e || wrap !== (k == 256)) begin
          n_bad++;
          $display("FAIL bin_dn[%0d]: out=%h wrap=%b required out=%h wrap=%b", k, out, wrap, e, (k == 256));
        end
      end else if (wrap !== 1'b0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL bin_early_wrap[%0d]: wrap=%b required 0", k, wrap);
      end
    end
    mode = 2'b11;
    dir  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      n_cmp++;
      if (out !== g[i]) begin
        n_bad++;
        $display("FAIL gray[%0d]: out=%h required %h", i, out, g[i]);
      end
    end
  endtask

  task automatic test_recovery();
    en = 1'b0;
    mode = 2'b00;
    step();
    force dut.state = 8'h55;
    #1 release dut.state;
    step();
    n_cmp++;
    if (out !== 8'h00 || err !== 1'b1) begin
      n_bad++;
      $display("FAIL johnson_fix: out=%h err=%b required out=00 err=1", out, err);
    end
    step();
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL johnson_err_pulse: err=%b required 0", err);
    end
    mode = 2'b01;
    step();
    force dut.state = 8'h03;
    #1 release dut.state;
    step();
    n_cmp++;
    if (out !== 8'h01 || err !== 1'b1) begin
      n_bad++;
      $display("FAIL ring_fix: out=%h err=%b required out=01 err=1", out, err);
    end
    step();
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL ring_err_pulse: err=%b required 0", err);
    end
    mode = 2'b10;
    step();
    force dut.state = 8'h55;
    #1 release dut.state;
    step();
    n_cmp++;
    if (out !== 8'h55 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL bin_keep: out=%h err=%b required out=55 err=0", out, err);
    end
    en = 1'b1;
    step();
    n_cmp++;
    if (out !== 8'h56) begin
      n_bad++;
      $display("FAIL bin_after_force: out=%h required 56", out);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] j [6] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F};
    mode = 2'b00;
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++;
      if (out !== j[i]) begin
        n_bad++;
        $display("FAIL ar_pre[%0d]: out=%h required %h", i, out, j[i]);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out, wrap, err} !== 10'h000) begin
      n_bad++;
      $display("FAIL async_reset: out=%h wrap=%b err=%b required out=00 wrap=0 err=0", out, wrap, err);
    end
    mode = 2'b01;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (out !== 8'h01) begin
      n_bad++;
      $display("FAIL post_reset_ring: out=%h required 01", out);
    end
  endtask

  initial begin
    test_reset();
    test_johnson();
    test_ring();
    test_prescaler();
    test_binary_gray();
    test_recovery();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
